game_timer_ctl: RTL and testbench

Parametrised countdown timer for the game datapath, replacing the fixed 20-tick, separately-clocked timer. It runs entirely in the system clock domain, with the second-rate tick arriving as a one-cycle enable strobe. Beyond plain countdown it adds:

- explicit start and pause control;
- saturating bonus-time addition;
- a low-time warning flag;
- a one-cycle expiry pulse alongside the level `game_end`.

It sits between the input/scoring logic and the seven-segment/score display path.

---
 rtl/game_timer_ctl.sv | 97 +++++++++
 tb/tb_game_timer_ctl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/game_timer_ctl.sv
// Countdown game timer in the system clock domain: start/pause control, low-time warning, expiry pulse.
// Optional saturating bonus addition is built only when GAME_TIMER_BONUS_EN is defined.
module game_timer_ctl #(
    parameter int WIDTH = 6,
    parameter int START = 20,
    parameter int MAX   = 63,
    parameter int WARN  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             start,
    input  logic             pause_tog,
    input  logic             bonus_valid,
    input  logic [WIDTH-1:0] bonus_amt,
    output logic [WIDTH-1:0] time_remaining,
    output logic [1:0]       state,
    output logic             warning,
    output logic             game_end,
    output logic             expire_pulse
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2, EXPIRED = 2'd3} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             pulse_q;
    logic [WIDTH-1:0] bonused;
    logic [WIDTH-1:0] run_next;

`ifdef GAME_TIMER_BONUS_EN
    // Sum is one bit wider so it clamps at MAX instead of wrapping.
    logic [WIDTH:0] sum;
    always_comb begin
        sum = {1'b0, cnt_q} + (bonus_valid ? {1'b0, bonus_amt} : '0);
        if (sum > (WIDTH+1)'(MAX))
            bonused = WIDTH'(MAX);
        else
            bonused = sum[WIDTH-1:0];
    end
`else
    logic unused_bonus;
    assign unused_bonus = ^{bonus_valid, bonus_amt, WIDTH'(MAX)};
    assign bonused      = cnt_q;
`endif

    assign run_next = bonused - {{(WIDTH-1){1'b0}}, tick};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (start) begin
            state_d = RUN;
            cnt_d   = WIDTH'(START);
        end else begin
            case (state_q)
                RUN: begin
                    if (pause_tog) begin
                        state_d = PAUSED;
                    end else begin
                        cnt_d = run_next;
                        if (run_next == '0)
                            state_d = EXPIRED;
                    end
                end
                PAUSED: begin
                    if (pause_tog)
                        state_d = RUN;
                    else
                        cnt_d = bonused;
                end
                EXPIRED: cnt_d = '0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= WIDTH'(START);
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= (state_d == EXPIRED) && (state_q != EXPIRED);
        end
    end

    assign time_remaining = cnt_q;
    assign state          = state_q;
    assign game_end       = (state_q == EXPIRED);
    assign expire_pulse   = pulse_q;
    assign warning        = ((state_q == RUN) || (state_q == PAUSED)) &&
                            (cnt_q != '0) && (cnt_q <= WIDTH'(WARN));

endmodule

// File: tb/tb_game_timer_ctl.sv
// Directed self-checking bench for game_timer_ctl (default parameters).
module tb_game_timer_ctl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0, start = 1'b0, pause_tog = 1'b0, bonus_valid = 1'b0;
    logic [5:0] bonus_amt = '0;
    logic [5:0] time_remaining;
    logic [1:0] state;
    logic       warning, game_end, expire_pulse;
    int         n_cmp = 0;
    int         n_bad = 0;

    game_timer_ctl dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .pause_tog(pause_tog),
        .bonus_valid(bonus_valid), .bonus_amt(bonus_amt), .time_remaining(time_remaining),
        .state(state), .warning(warning), .game_end(game_end), .expire_pulse(expire_pulse)
    );

    always #5 clk = ~clk;

    // Drive inputs for one rising edge, then return at the following falling edge.
    task automatic step(input logic t, input logic s, input logic p, input logic bv, input logic [5:0] ba);
        tick = t; start = s; pause_tog = p; bonus_valid = bv; bonus_amt = ba;
        @(posedge clk);
        #1;
        tick = 0; start = 0; pause_tog = 0; bonus_valid = 0; bonus_amt = '0;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        chk("reset count", time_remaining, 20);
        chk("reset state", state, 0);
        chk("reset warning", warning, 0);
        chk("reset game_end", game_end, 0);
        chk("reset expire_pulse", expire_pulse, 0);
        step(1, 0, 1, 1, 6'd3);
        chk("idle ignores count", time_remaining, 20);
        chk("idle ignores state", state, 0);
    endtask

    task automatic test_countdown();
        step(0, 1, 0, 0, 0);
        chk("start state", state, 1);
        chk("start count", time_remaining, 20);
        for (int i = 1; i <= 20; i++) begin
            step(1, 0, 0, 0, 0);
            chk("cd count", time_remaining, 20 - i);
            chk("cd warning", warning, ((20 - i) >= 1 && (20 - i) <= 5) ? 1 : 0);
            chk("cd game_end", game_end, (i == 20) ? 1 : 0);
            chk("cd expire_pulse", expire_pulse, (i == 20) ? 1 : 0);
        end
        chk("cd expired state", state, 3);
        step(1, 0, 0, 0, 0);
        chk("pulse one cycle", expire_pulse, 0);
        chk("game_end level", game_end, 1);
        chk("count floor", time_remaining, 0);
    endtask

    task automatic test_pause();
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        chk("pre-pause count", time_remaining, 17);
        step(1, 0, 1, 0, 0);
        chk("paused state", state, 2);
        chk("pause drops tick", time_remaining, 17);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0);
        chk("paused hold", time_remaining, 17);
        step(0, 0, 1, 0, 0);
        chk("resume state", state, 1);
        step(1, 0, 0, 0, 0);
        chk("resume tick", time_remaining, 16);
    endtask

    task automatic test_bonus();
        step(0, 1, 0, 0, 0);
`ifdef GAME_TIMER_BONUS_EN
        step(0, 0, 0, 1, 6'd40);
        chk("bonus add", time_remaining, 60);
        step(0, 0, 0, 1, 6'd10);
        chk("bonus saturate", time_remaining, 63);
        step(1, 0, 0, 1, 6'd5);
        chk("sat then tick", time_remaining, 62);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 19; i++) step(1, 0, 0, 0, 0);
        chk("bonus at 1 pre", time_remaining, 1);
        step(1, 0, 0, 1, 6'd4);
        chk("bonus+tick count", time_remaining, 4);
        chk("bonus+tick no expiry", game_end, 0);
        chk("bonus+tick no pulse", expire_pulse, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 6'd63);
        chk("paused bonus sat", time_remaining, 63);
        chk("paused bonus state", state, 2);
`else
        step(0, 0, 0, 1, 6'd10);
        chk("bonus ignored", time_remaining, 20);
        step(1, 0, 0, 1, 6'd10);
        chk("bonus ignored tick", time_remaining, 19);
`endif
    endtask

    task automatic test_expired_lock();
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0);
        chk("lock expired", state, 3);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 6'd9);
        step(0, 0, 1, 0, 0);
        step(1, 0, 1, 1, 6'd9);
        chk("lock count", time_remaining, 0);
        chk("lock state", state, 3);
        chk("lock no pulse", expire_pulse, 0);
        step(0, 1, 0, 0, 0);
        chk("restart count", time_remaining, 20);
        chk("restart state", state, 1);
        chk("restart game_end", game_end, 0);
    endtask

    task automatic test_simultaneous();
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 13; i++) step(1, 0, 0, 0, 0);
        chk("simul pre count", time_remaining, 7);
        step(1, 1, 1, 1, 6'd5);
        chk("simul state", state, 1);
        chk("simul count", time_remaining, 20);
    endtask

    task automatic test_async_reset();
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 11; i++) step(1, 0, 0, 0, 0);
        chk("async pre count", time_remaining, 9);
        #2 rst_n = 0;
        #1;
        chk("async count", time_remaining, 20);
        chk("async state", state, 0);
        chk("async game_end", game_end, 0);
        chk("async pulse", expire_pulse, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("post reset idle", state, 0);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_countdown();
        test_pause();
        test_bonus();
        test_expired_lock();
        test_simultaneous();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
